// File: rtl/logic_axi4_stream_tdest_balancer.sv
// Packet-coherent round-robin tdest assigner for an AXI4-Stream demux.
// Each packet is given one demux output index. Outputs rotate per packet, and any output
// flagged busy at packet start is skipped. There is one registered stage with full throughput.
module logic_axi4_stream_tdest_balancer #(
  parameter int unsigned OUTPUTS     = 2,
  parameter int unsigned TDATA_BYTES = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned USE_TKEEP   = 1,
  parameter int unsigned USE_TSTRB   = 1,
  parameter int unsigned USE_TLAST   = 1,
  // Disabled fields keep a 1-bit port that is driven to a constant.
  localparam int unsigned DataW = (TDATA_BYTES != 0) ? TDATA_BYTES * 8 : 1,
  localparam int unsigned KeepW = (TDATA_BYTES != 0) ? TDATA_BYTES : 1,
  localparam int unsigned UserW = (TUSER_WIDTH != 0) ? TUSER_WIDTH : 1,
  localparam int unsigned IdW   = (TID_WIDTH != 0) ? TID_WIDTH : 1,
  localparam int unsigned PtrW  = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [OUTPUTS-1:0]     busy,
  // Upstream stream
  input  logic                   rx_tvalid_i,
  output logic                   rx_tready_o,
  input  logic [DataW-1:0]       rx_tdata_i,
  input  logic [KeepW-1:0]       rx_tkeep_i,
  input  logic [KeepW-1:0]       rx_tstrb_i,
  input  logic                   rx_tlast_i,
  input  logic [UserW-1:0]       rx_tuser_i,
  input  logic [IdW-1:0]         rx_tid_i,
  // Stream to the demux
  output logic                   tx_tvalid_o,
  input  logic                   tx_tready_i,
  output logic [DataW-1:0]       tx_tdata_o,
  output logic [KeepW-1:0]       tx_tkeep_o,
  output logic [KeepW-1:0]       tx_tstrb_o,
  output logic                   tx_tlast_o,
  output logic [UserW-1:0]       tx_tuser_o,
  output logic [IdW-1:0]         tx_tid_o,
  output logic [TDEST_WIDTH-1:0] tx_tdest_o
);

  if (OUTPUTS < 2) begin : gen_outputs_too_few
    $error("OUTPUTS must be at least 2");
  end
  if (TDEST_WIDTH < $clog2(OUTPUTS)) begin : gen_tdest_too_narrow
    $error("TDEST_WIDTH must be at least $clog2(OUTPUTS)");
  end

  // Adds a scan offset to base and wraps the result at OUTPUTS. OUTPUTS need not be a power of two.
  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= OUTPUTS) s = s - OUTPUTS;
    return PtrW'(s);
  endfunction

  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [PtrW-1:0]        cur_q, cur_d;
  logic                   in_packet_q, in_packet_d;
  logic                   tx_tvalid_q;
  logic [TDEST_WIDTH-1:0] tx_tdest_q;
  logic [DataW-1:0]       tdata_q;
  logic [KeepW-1:0]       tkeep_q, tstrb_q;
  logic                   tlast_q;
  logic [UserW-1:0]       tuser_q;
  logic [IdW-1:0]         tid_q;

  logic                   en, accept;
  logic                   found;
  logic [PtrW-1:0]        sel, route, cand;

  // Find the first non-busy output, scanning upward from the round-robin pointer.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    cand  = ptr_q;
    for (int unsigned i = 0; i < OUTPUTS; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!found && !busy[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Handshake and routing. Busy outputs can stall only a packet start, never a beat inside a packet.
  always_comb begin
    en          = !tx_tvalid_q || tx_tready_i;
    rx_tready_o = en && (in_packet_q || !(&busy));
    accept      = rx_tvalid_i && rx_tready_o;
    route       = in_packet_q ? cur_q : sel;
  end

  // Next-state for the pointer, the locked index, and packet tracking.
  always_comb begin
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    in_packet_d = in_packet_q;
    if (accept) begin
      if (!in_packet_q) begin
        cur_d = sel;
        ptr_d = (sel == PtrW'(OUTPUTS - 1)) ? '0 : sel + PtrW'(1);
      end
      in_packet_d = (USE_TLAST != 0) ? !rx_tlast_i : 1'b0;
    end
  end

  // Control state and tx valid/tdest are cleared asynchronously by reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr_q       <= '0;
      cur_q       <= '0;
      in_packet_q <= 1'b0;
      tx_tvalid_q <= 1'b0;
      tx_tdest_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      in_packet_q <= in_packet_d;
      if (en) begin
        tx_tvalid_q <= accept;
        tx_tdest_q  <= TDEST_WIDTH'(route);
      end
    end
  end

  // Payload registers are not reset because they are qualified by tx_tvalid.
  always_ff @(posedge aclk) begin
    if (en) begin
      tdata_q <= rx_tdata_i;
      tkeep_q <= rx_tkeep_i;
      tstrb_q <= rx_tstrb_i;
      tlast_q <= rx_tlast_i;
      tuser_q <= rx_tuser_i;
      tid_q   <= rx_tid_i;
    end
  end

  // Output drive, with disabled fields tied to their defaults.
  always_comb begin
    tx_tvalid_o = tx_tvalid_q;
    tx_tdest_o  = tx_tdest_q;
    tx_tdata_o  = (TDATA_BYTES != 0) ? tdata_q : '0;
    tx_tkeep_o  = (TDATA_BYTES != 0 && USE_TKEEP != 0) ? tkeep_q : '1;
    tx_tstrb_o  = (TDATA_BYTES != 0 && USE_TSTRB != 0) ? tstrb_q : '1;
    tx_tlast_o  = (USE_TLAST != 0) ? tlast_q : 1'b1;
    tx_tuser_o  = (TUSER_WIDTH != 0) ? tuser_q : '0;
    tx_tid_o    = (TID_WIDTH != 0) ? tid_q : '0;
  end

endmodule

// File: tb/tb_logic_axi4_stream_tdest_balancer.sv
// Self-checking bench for logic_axi4_stream_tdest_balancer with OUTPUTS = 3.
module tb_logic_axi4_stream_tdest_balancer;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       s;
    logic [1:0] u;
    logic [1:0] id;
    logic       l;
    logic [1:0] dest;
  } beat_t;

  logic       aclk = 1'b0;
  logic       areset;
  logic [2:0] busy;
  logic       rx_tvalid_i, rx_tready_o;
  logic [7:0] rx_tdata_i;
  logic       rx_tkeep_i, rx_tstrb_i, rx_tlast_i;
  logic [1:0] rx_tuser_i, rx_tid_i;
  logic       tx_tvalid_o, tx_tready_i;
  logic [7:0] tx_tdata_o;
  logic       tx_tkeep_o, tx_tstrb_o, tx_tlast_o;
  logic [1:0] tx_tuser_o, tx_tid_o, tx_tdest_o;

  int errors = 0;
  int checks = 0;

  logic_axi4_stream_tdest_balancer #(
    .OUTPUTS    (3),
    .TDATA_BYTES(1),
    .TDEST_WIDTH(2),
    .TUSER_WIDTH(2),
    .TID_WIDTH  (2),
    .USE_TKEEP  (1),
    .USE_TSTRB  (1),
    .USE_TLAST  (1)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .busy       (busy),
    .rx_tvalid_i(rx_tvalid_i),
    .rx_tready_o(rx_tready_o),
    .rx_tdata_i (rx_tdata_i),
    .rx_tkeep_i (rx_tkeep_i),
    .rx_tstrb_i (rx_tstrb_i),
    .rx_tlast_i (rx_tlast_i),
    .rx_tuser_i (rx_tuser_i),
    .rx_tid_i   (rx_tid_i),
    .tx_tvalid_o(tx_tvalid_o),
    .tx_tready_i(tx_tready_i),
    .tx_tdata_o (tx_tdata_o),
    .tx_tkeep_o (tx_tkeep_o),
    .tx_tstrb_o (tx_tstrb_o),
    .tx_tlast_o (tx_tlast_o),
    .tx_tuser_o (tx_tuser_o),
    .tx_tid_o   (tx_tid_o),
    .tx_tdest_o (tx_tdest_o)
  );

  always #5 aclk = ~aclk;

  // Returns the first output that is not busy, scanning upward from p and wrapping modulo 3.
  function automatic int first_free(input int p, input logic [2:0] b);
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (p + k) % 3;
      if (!b[idx]) return idx;
    end
    return -1;
  endfunction

  // Holds reset across two edges, then releases it just after a rising edge.
  task automatic do_reset();
    areset      = 1'b1;
    busy        = 3'b000;
    rx_tvalid_i = 1'b0;
    rx_tdata_i  = '0;
    rx_tkeep_i  = 1'b1;
    rx_tstrb_i  = 1'b1;
    rx_tlast_i  = 1'b1;
    rx_tuser_i  = '0;
    rx_tid_i    = '0;
    tx_tready_i = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic test_reset();
    areset      = 1'b1;
    busy        = 3'b000;
    rx_tvalid_i = 1'b0;
    tx_tready_i = 1'b0;
    #2;
    checks++;
    if (tx_tvalid_o !== 1'b0 || tx_tdest_o !== 2'd0)
      $display("FAIL reset_state: tvalid=%b tdest=%0d, expected 0 0", tx_tvalid_o, tx_tdest_o);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (rx_tready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_rx_ready: rx_tready=%b, expected 1", rx_tready_o);
    end
    checks++;
    if (tx_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: tvalid=%b, expected 0", tx_tvalid_o);
    end
    @(posedge aclk); #1;
  endtask

  // Six one-beat packets sent back to back. tdest should rotate 0,1,2 and each beat appears one cycle later.
  task automatic test_single_beats();
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        rx_tvalid_i = 1'b1;
        rx_tdata_i  = 8'(8'h10 + i);
        rx_tlast_i  = 1'b1;
      end else begin
        rx_tvalid_i = 1'b0;
      end
      @(negedge aclk);
      if (i < 6) begin
        checks++;
        if (rx_tready_o !== 1'b1) begin
          errors++;
          $display("FAIL single_ready%0d: rx_tready=%b, expected 1", i, rx_tready_o);
        end
      end
      if (i > 0) begin
        checks++;
        if (tx_tvalid_o !== 1'b1 || tx_tdest_o !== 2'((i - 1) % 3) ||
            tx_tdata_o !== 8'(8'h10 + i - 1)) begin
          errors++;
          $display("FAIL single_beat%0d: tvalid=%b tdest=%0d data=%h, expected 1 %0d %h", i - 1,
                   tx_tvalid_o, tx_tdest_o, tx_tdata_o, (i - 1) % 3, 8'(8'h10 + i - 1));
        end
      end
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    checks++;
    if (tx_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: tvalid=%b, expected 0", tx_tvalid_o);
    end
    @(posedge aclk); #1;
  endtask

  // Two 4-beat packets. Setting busy[0] in the middle of the first packet must not move it to another output.
  task automatic test_busy_midpacket();
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        rx_tvalid_i = 1'b1;
        rx_tdata_i  = 8'(8'h40 + i);
        rx_tlast_i  = (i == 3 || i == 7);
        busy        = (i == 0) ? 3'b000 : 3'b001;
      end else begin
        rx_tvalid_i = 1'b0;
      end
      @(negedge aclk);
      if (i > 0) begin
        checks++;
        if (tx_tvalid_o !== 1'b1 || tx_tdest_o !== ((i - 1 < 4) ? 2'd0 : 2'd1) ||
            tx_tdata_o !== 8'(8'h40 + i - 1)) begin
          errors++;
          $display("FAIL midpkt_beat%0d: tvalid=%b tdest=%0d data=%h, expected 1 %0d %h", i - 1,
                   tx_tvalid_o, tx_tdest_o, tx_tdata_o, (i - 1 < 4) ? 0 : 1, 8'(8'h40 + i - 1));
        end
      end
      @(posedge aclk); #1;
    end
    busy = 3'b000;
  endtask

  // With busy = 011, routing goes to output 2 and the pointer wraps back to 0.
  task automatic test_skip_busy();
    do_reset();
    for (int i = 0; i <= 2; i++) begin
      if (i < 2) begin
        rx_tvalid_i = 1'b1;
        rx_tdata_i  = 8'(8'h70 + i);
        rx_tlast_i  = 1'b1;
        busy        = (i == 0) ? 3'b011 : 3'b000;
      end else begin
        rx_tvalid_i = 1'b0;
      end
      @(negedge aclk);
      if (i > 0) begin
        checks++;
        if (tx_tvalid_o !== 1'b1 || tx_tdest_o !== ((i == 1) ? 2'd2 : 2'd0) ||
            tx_tdata_o !== 8'(8'h70 + i - 1)) begin
          errors++;
          $display("FAIL skip_beat%0d: tvalid=%b tdest=%0d data=%h, expected 1 %0d %h", i - 1,
                   tx_tvalid_o, tx_tdest_o, tx_tdata_o, (i == 1) ? 2 : 0, 8'(8'h70 + i - 1));
        end
      end
      @(posedge aclk); #1;
    end
  endtask

  // When all outputs are busy at packet start, the beat is held back until an output frees up.
  task automatic test_all_busy();
    do_reset();
    busy        = 3'b111;
    rx_tvalid_i = 1'b1;
    rx_tdata_i  = 8'hA5;
    rx_tlast_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (rx_tready_o !== 1'b0 || tx_tvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL all_busy%0d: rx_tready=%b tvalid=%b, expected 0 0", i, rx_tready_o,
                 tx_tvalid_o);
      end
      @(posedge aclk); #1;
    end
    busy = 3'b101;
    @(negedge aclk);
    checks++;
    if (rx_tready_o !== 1'b1) begin
      errors++;
      $display("FAIL all_busy_release: rx_tready=%b, expected 1", rx_tready_o);
    end
    @(posedge aclk); #1;
    rx_tvalid_i = 1'b0;
    busy        = 3'b000;
    @(negedge aclk);
    checks++;
    if (tx_tvalid_o !== 1'b1 || tx_tdest_o !== 2'd1 || tx_tdata_o !== 8'hA5) begin
      errors++;
      $display("FAIL all_busy_out: tvalid=%b tdest=%0d data=%h, expected 1 1 a5", tx_tvalid_o,
               tx_tdest_o, tx_tdata_o);
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (tx_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL all_busy_dup: tvalid=%b, expected 0", tx_tvalid_o);
    end
    @(posedge aclk); #1;
  endtask

  // Pulse reset during beat 2 of a 4-beat packet that was routed to output 1.
  task automatic test_reset_midpacket();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rx_tvalid_i = 1'b1;
      rx_tdata_i  = 8'(8'hB0 + i);
      rx_tlast_i  = (i == 0);
      @(posedge aclk); #1;
    end
    rx_tdata_i = 8'hB3;
    rx_tlast_i = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    #1;
    checks++;
    if (tx_tvalid_o !== 1'b0 || tx_tdest_o !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_async: tvalid=%b tdest=%0d, expected 0 0", tx_tvalid_o, tx_tdest_o);
    end
    rx_tvalid_i = 1'b0;
    @(posedge aclk); #1 areset = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      if (i < 2) begin
        rx_tvalid_i = 1'b1;
        rx_tdata_i  = 8'(8'hC0 + i);
        rx_tlast_i  = 1'b1;
      end else begin
        rx_tvalid_i = 1'b0;
      end
      @(negedge aclk);
      if (i > 0) begin
        checks++;
        if (tx_tvalid_o !== 1'b1 || tx_tdest_o !== 2'(i - 1) ||
            tx_tdata_o !== 8'(8'hC0 + i - 1)) begin
          errors++;
          $display("FAIL rst_mid_after%0d: tvalid=%b tdest=%0d data=%h, expected 1 %0d %h", i - 1,
                   tx_tvalid_o, tx_tdest_o, tx_tdata_o, i - 1, 8'(8'hC0 + i - 1));
        end
      end
      @(posedge aclk); #1;
    end
  endtask

  // 200 random-length packets with random busy and tx_tready, checked against a packet-level model.
  task automatic test_random();
    beat_t exp_q[$];
    beat_t got, want, prev_out;
    bit    prev_stall = 1'b0;
    bit    m_inpkt = 1'b0;
    bit    acc;
    int    m_ptr = 0, m_cur = 0, d;
    int    pkt = 0, beat = 0, len, cyc = 0;
    do_reset();
    len         = $urandom_range(1, 6);
    rx_tdata_i  = 8'($urandom);
    rx_tkeep_i  = 1'($urandom);
    rx_tstrb_i  = 1'($urandom);
    rx_tuser_i  = 2'($urandom);
    rx_tid_i    = 2'($urandom);
    rx_tlast_i  = (len == 1);
    prev_out    = '0;
    while ((pkt < 200 || exp_q.size() != 0) && cyc < 20000) begin
      if (!rx_tvalid_i && pkt < 200 && $urandom_range(0, 4) != 0) rx_tvalid_i = 1'b1;
      busy        = 3'($urandom_range(0, 7));
      tx_tready_i = 1'($urandom_range(0, 1));
      @(negedge aclk);
      got = {tx_tdata_o, tx_tkeep_o, tx_tstrb_o, tx_tuser_o, tx_tid_o, tx_tlast_o, tx_tdest_o};
      if (prev_stall) begin
        checks++;
        if (tx_tvalid_o !== 1'b1 || got !== prev_out) begin
          errors++;
          $display("FAIL rand_stable cyc%0d: tvalid=%b fields=%h, expected 1 %h", cyc,
                   tx_tvalid_o, got, prev_out);
        end
      end
      if (tx_tvalid_o && tx_tready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra cyc%0d: output beat %h, expected none", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL rand_beat cyc%0d: got %h, expected %h", cyc, got, want);
          end
        end
      end
      if (tx_tvalid_o && !tx_tready_i) begin
        checks++;
        if (rx_tready_o !== 1'b0) begin
          errors++;
          $display("FAIL rand_backpressure cyc%0d: rx_tready=%b, expected 0", cyc, rx_tready_o);
        end
      end else if (rx_tvalid_i && !m_inpkt && busy == 3'b111) begin
        checks++;
        if (rx_tready_o !== 1'b0) begin
          errors++;
          $display("FAIL rand_allbusy cyc%0d: rx_tready=%b, expected 0", cyc, rx_tready_o);
        end
      end
      acc = rx_tvalid_i && rx_tready_o;
      if (acc) begin
        if (!m_inpkt) begin
          d     = first_free(m_ptr, busy);
          m_cur = d;
          m_ptr = (d + 1) % 3;
        end else begin
          d = m_cur;
        end
        m_inpkt = !rx_tlast_i;
        exp_q.push_back({rx_tdata_i, rx_tkeep_i, rx_tstrb_i, rx_tuser_i, rx_tid_i, rx_tlast_i,
                         2'(d)});
      end
      prev_stall = tx_tvalid_o && !tx_tready_i;
      prev_out   = got;
      @(posedge aclk); #1;
      cyc++;
      if (acc) begin
        rx_tvalid_i = 1'b0;
        beat++;
        if (beat == len) begin
          pkt++;
          beat = 0;
          len  = $urandom_range(1, 6);
        end
        rx_tdata_i = 8'($urandom);
        rx_tkeep_i = 1'($urandom);
        rx_tstrb_i = 1'($urandom);
        rx_tuser_i = 2'($urandom);
        rx_tid_i   = 2'($urandom);
        rx_tlast_i = (beat == len - 1);
      end
    end
    rx_tvalid_i = 1'b0;
    checks++;
    if (cyc >= 20000 || exp_q.size() != 0 || pkt != 200) begin
      errors++;
      $display("FAIL rand_complete: packets=%0d pending=%0d cycles=%0d, expected 200 0 <20000",
               pkt, exp_q.size(), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_beats();
    test_busy_midpacket();
    test_skip_busy();
    test_all_busy();
    test_reset_midpacket();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
